// File: rtl/shift_pipe_pkg.sv
// shift_pipe_pkg
// Shared constants for the pipelined shift unit.
//   SHIFT_OP_*  : 2-bit opcode encodings carried with every operation
//   FINE_BITS   : number of low shift-amount bits applied in stage 2;
//                 all higher bits are applied in stage 1
//   is_right_op : helper that tells whether an opcode shifts toward bit 0
package shift_pipe_pkg;

  localparam logic [1:0] SHIFT_OP_SLL = 2'b00;
  localparam logic [1:0] SHIFT_OP_SRL = 2'b01;
  localparam logic [1:0] SHIFT_OP_SRA = 2'b10;
  localparam logic [1:0] SHIFT_OP_ROL = 2'b11;

  localparam int FINE_BITS = 3;

  function automatic logic is_right_op(input logic [1:0] op);
    return (op == SHIFT_OP_SRL) || (op == SHIFT_OP_SRA);
  endfunction

endpackage

// File: rtl/shift_pipe_level.sv
// shift_level
// One combinational level of the shifter: conditionally moves the word by a
// fixed distance DIST.
//   data   : word entering this level
//   enable : apply the shift (the corresponding shift-amount bit)
//   dir    : 0 = toward the MSB (left), 1 = toward the LSB (right)
//   fill   : value inserted into vacated positions
//   rotate : on a left move, reinsert the bits pushed out of the MSB end
//   result : word leaving this level
module shift_level #(
  parameter int WIDTH = 32,
  parameter int DIST  = 16
) (
  input  logic [WIDTH-1:0] data,
  input  logic             enable,
  input  logic             dir,
  input  logic             fill,
  input  logic             rotate,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] left_moved;
  logic [WIDTH-1:0] right_moved;

  // Both directions are built and selected; rotate only ever applies to the
  // left direction, so the wrapped bits come from the top DIST bits.
  always_comb begin
    left_moved = {data[WIDTH-DIST-1:0], {DIST{fill}}};
    if (rotate) begin
      left_moved = {data[WIDTH-DIST-1:0], data[WIDTH-1:WIDTH-DIST]};
    end
    right_moved = {{DIST{fill}}, data[WIDTH-1:DIST]};
    result = data;
    if (enable) begin
      result = dir ? right_moved : left_moved;
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// shift_pipe
// Two-stage pipelined shift unit (SLL, SRL, SRA, optional ROL).
// Stage 1 applies the coarse levels (shift-amount bits SHW-1..3), stage 2
// the fine levels (bits 2..0). One operation per cycle, latency 2.
// Optional feature macro: SHIFT_PIPE_ROTATE_EN -- when defined, op 11 rotates
// left; when undefined, op 11 behaves as SLL.
// Ports:
//   clock, reset_n          : rising-edge clock, synchronous active-low reset
//   in_valid/in_ready       : input handshake
//   in_data, in_shamt       : operand and unsigned shift amount
//   in_op, in_tag           : opcode and destination tag
//   out_valid/out_ready     : output handshake
//   out_data, out_tag       : result and its tag (registered, from stage 2)
module shift_pipe
  import shift_pipe_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int TAG_W = 5,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int COARSE = SHW - FINE_BITS;

  logic                 adv1, adv2, in_fire;
  logic                 in_dir, in_fill, in_rot;
  logic                 s1_dir, s1_rot;

  logic                 s1_valid;
  logic [WIDTH-1:0]     s1_data;
  logic [FINE_BITS-1:0] s1_shamt;
  logic [1:0]           s1_op;
  logic [TAG_W-1:0]     s1_tag;
  logic                 s1_fill;

  logic                 s2_valid;
  logic [WIDTH-1:0]     s2_data;
  logic [TAG_W-1:0]     s2_tag;

  logic [WIDTH-1:0]     coarse_data [0:COARSE];
  logic [WIDTH-1:0]     fine_data   [0:FINE_BITS];

  // A stage may take new contents whenever its successor will make room.
  assign adv2     = !s2_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1 && reset_n;
  assign in_fire  = in_valid && in_ready;

  // The SRA fill is the operand's original MSB; it is captured in s1 because
  // after the coarse levels the MSB of the partial result may already be fill.
  assign in_dir  = is_right_op(in_op);
  assign in_fill = (in_op == SHIFT_OP_SRA) && in_data[WIDTH-1];
  assign s1_dir  = is_right_op(s1_op);
`ifdef SHIFT_PIPE_ROTATE_EN
  assign in_rot  = (in_op == SHIFT_OP_ROL);
  assign s1_rot  = (s1_op == SHIFT_OP_ROL);
`else
  assign in_rot  = 1'b0;
  assign s1_rot  = 1'b0;
`endif

  assign coarse_data[0] = in_data;
  for (genvar i = 0; i < COARSE; i++) begin : g_coarse
    localparam int LVL = SHW - 1 - i;
    shift_level #(.WIDTH(WIDTH), .DIST(1 << LVL)) u_level (
      .data   (coarse_data[i]),
      .enable (in_shamt[LVL]),
      .dir    (in_dir),
      .fill   (in_fill),
      .rotate (in_rot),
      .result (coarse_data[i+1])
    );
  end

  assign fine_data[0] = s1_data;
  for (genvar i = 0; i < FINE_BITS; i++) begin : g_fine
    localparam int LVL = FINE_BITS - 1 - i;
    shift_level #(.WIDTH(WIDTH), .DIST(1 << LVL)) u_level (
      .data   (fine_data[i]),
      .enable (s1_shamt[LVL]),
      .dir    (s1_dir),
      .fill   (s1_fill),
      .rotate (s1_rot),
      .result (fine_data[i+1])
    );
  end

  // Stage 1 captures the coarse-shifted operand plus what stage 2 still needs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_shamt <= '0;
      s1_op    <= SHIFT_OP_SLL;
      s1_tag   <= '0;
      s1_fill  <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_data  <= coarse_data[COARSE];
        s1_shamt <= in_shamt[FINE_BITS-1:0];
        s1_op    <= in_op;
        s1_tag   <= in_tag;
        s1_fill  <= in_fill;
      end
    end
  end

  // Stage 2 holds the finished result; the payload only changes when a real
  // operation moves in, so the last result stays visible across bubbles.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_tag   <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= fine_data[FINE_BITS];
        s2_tag  <= s1_tag;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_tag   = s2_tag;

endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe
// Scoreboard bench for shift_pipe: the driver pushes the reference result of
// every accepted operation, a monitor pops and compares on every output
// transfer. Honours SHIFT_PIPE_ROTATE_EN in its reference model.
module tb_shift_pipe;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;
  localparam int SHW   = 5;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  exp_t sb[$];
  int   xfer_log[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   rand_ready = 0;
  bit   ready_level = 0;

  shift_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Downstream readiness changes only on the falling edge.
  always @(negedge clock) begin
    out_ready = rand_ready ? 1'($urandom_range(1, 0)) : ready_level;
  end

  // Reference model straight from the opcode definitions.
  function automatic logic [WIDTH-1:0] ref_model(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] d,
                                                 input int sh);
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = d << sh;
      2'b01:   r = d >> sh;
      2'b10:   r = $signed(d) >>> sh;
`ifdef SHIFT_PIPE_ROTATE_EN
      default: r = (sh == 0) ? d : ((d << sh) | (d >> (WIDTH - sh)));
`else
      default: r = d << sh;
`endif
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Offer one operation starting at a falling edge; returns on the falling
  // edge after it was accepted, leaving in_valid asserted.
  task automatic applyStimulus(input logic [1:0] op, input logic [WIDTH-1:0] d,
                               input int sh, input logic [TAG_W-1:0] tag);
    int waited = 0;
    exp_t e;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_shamt = SHW'(sh);
    in_tag   = tag;
    #1;
    while (!in_ready && waited < 200) begin
      @(negedge clock);
      #1;
      waited++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      e.data = ref_model(op, d, sh);
      e.tag  = tag;
      sb.push_back(e);
    end
    @(negedge clock);
  endtask

  // Monitor: a transfer happens at the next rising edge when both are high.
  always @(negedge clock) begin
    #2;
    if (reset_n && out_valid && out_ready) begin
      xfer_log.push_back(cyc);
      if (sb.size() == 0) begin
        checkOutput("unexpected_result", out_data, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("result_data", out_data, e.data);
        checkOutput("result_tag", 32'(out_tag), 32'(e.tag));
      end
    end
  end

  initial begin
    int n;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_shamt = '0;
    in_op    = '0;
    in_tag   = '0;

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", out_data, 32'd0);
    checkOutput("reset_out_tag", 32'(out_tag), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    #1;
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
    ready_level = 1'b1;

    // Latency: SLL 1 by 31, tag 7
    @(negedge clock);
    applyStimulus(2'b00, 32'h0000_0001, 31, 5'd7);
    in_valid = 1'b0;
    #1;
    checkOutput("latency_not_early", 32'(out_valid), 32'd0);
    @(negedge clock);
    #1;
    checkOutput("latency_valid", 32'(out_valid), 32'd1);
    checkOutput("latency_data", out_data, 32'h8000_0000);
    checkOutput("latency_tag", 32'(out_tag), 32'd7);
    @(negedge clock);

    // Back-to-back stream with no bubbles
    applyStimulus(2'b10, 32'h8000_0000, 4, 5'd1);
    applyStimulus(2'b01, 32'h8000_0000, 4, 5'd2);
    applyStimulus(2'b00, 32'hFFFF_FFFF, 0, 5'd3);
    in_valid = 1'b0;
    repeat (4) @(negedge clock);
    n = xfer_log.size();
    if (n >= 3) begin
      checkOutput("stream_gap1", 32'(xfer_log[n-2] - xfer_log[n-3]), 32'd1);
      checkOutput("stream_gap2", 32'(xfer_log[n-1] - xfer_log[n-2]), 32'd1);
    end else begin
      checkOutput("stream_count", 32'(n), 32'd3);
    end

    // Backpressure: fill both stages, stall 5 cycles
    ready_level = 1'b0;
    @(negedge clock);
    applyStimulus(2'b10, 32'hF0F0_0000, 8, 5'd10);
    applyStimulus(2'b01, 32'h1234_5678, 12, 5'd11);
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_out_data", out_data, 32'hFFF0_F000);
      checkOutput("stall_out_tag", 32'(out_tag), 32'd10);
      @(negedge clock);
    end
    ready_level = 1'b1;
    repeat (4) @(negedge clock);
    checkOutput("stall_drained", 32'(sb.size()), 32'd0);

    // Reset with two operations in flight
    ready_level = 1'b0;
    @(negedge clock);
    applyStimulus(2'b00, 32'h0000_00FF, 3, 5'd20);
    applyStimulus(2'b01, 32'hFF00_0000, 3, 5'd21);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    sb.delete();
    @(negedge clock);
    #1;
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_in_ready", 32'(in_ready), 32'd0);
    reset_n = 1'b1;
    ready_level = 1'b1;
    @(negedge clock);
    #1;
    checkOutput("midreset_release_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("midreset_no_ghost", 32'(out_valid), 32'd0);
      @(negedge clock);
      #1;
    end
    @(negedge clock);

    // Rotate / SLL-alias
    applyStimulus(2'b11, 32'h8000_0001, 1, 5'd30);
    in_valid = 1'b0;
    @(negedge clock);
    #1;
`ifdef SHIFT_PIPE_ROTATE_EN
    checkOutput("rol_data", out_data, 32'h0000_0003);
`else
    checkOutput("rol_data", out_data, 32'h0000_0002);
`endif
    @(negedge clock);

    // Random sweep with random backpressure
    rand_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(3, 0) == 0) begin
        in_valid = 1'b0;
        @(negedge clock);
      end
      applyStimulus(2'($urandom_range(3, 0)), $urandom, $urandom_range(31, 0),
                    TAG_W'($urandom_range(31, 0)));
    end
    in_valid = 1'b0;
    rand_ready = 1'b0;
    ready_level = 1'b1;
    for (int k = 0; k < 2000 && sb.size() != 0; k++) @(negedge clock);
    @(negedge clock);
    checkOutput("sweep_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
